comparador_seq: RTL and testbench



---
 rtl/comparador_seq.sv | 132 +++++++++++++
 tb/tb_comparador_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparador_seq.sv
// Multi-cycle magnitude/equality comparator: scans operands CHUNK bits per cycle
// from the MSB down and stops at the first differing chunk.
module comparador_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MODO,
  input  logic             SINAL,
  output logic             BUSY,
  output logic             DONE,
  output logic             IGUAL,
  output logic             MAIOR,
  output logic             MENOR,
  output logic             RESULTADO
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, COMPARA, FIM} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       modo_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q, done_q, igual_q, maior_q, menor_q, res_q;

  logic [WIDTH-1:0] msb_mask, cap_a_d, cap_b_d, sh_a, sh_b;
  logic [31:0]      shamt;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             chunk_gt;

  function automatic logic rel_sel(input logic [2:0] modo, input logic ig,
                                   input logic ma, input logic me);
    case (modo)
      3'b000:  rel_sel = ig;
      3'b001:  rel_sel = ~ig;
      3'b010:  rel_sel = me;
      3'b011:  rel_sel = me | ig;
      3'b100:  rel_sel = ma;
      3'b101:  rel_sel = ma | ig;
      default: rel_sel = 1'b0;
    endcase
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    msb_mask = '0;
    msb_mask[WIDTH-1] = 1'b1;
    cap_a_d  = A ^ ({WIDTH{SINAL}} & msb_mask);
    cap_b_d  = B ^ ({WIDTH{SINAL}} & msb_mask);
    shamt    = 32'(idx_q) * CHUNK;
    sh_a     = a_q << shamt;
    sh_b     = b_q << shamt;
    chunk_a  = sh_a[WIDTH-1 -: CHUNK];
    chunk_b  = sh_b[WIDTH-1 -: CHUNK];
    chunk_gt = (chunk_a > chunk_b);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      modo_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      igual_q <= 1'b0;
      maior_q <= 1'b0;
      menor_q <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            a_q     <= cap_a_d;
            b_q     <= cap_b_d;
            modo_q  <= MODO;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            igual_q <= 1'b0;
            maior_q <= 1'b0;
            menor_q <= 1'b0;
            res_q   <= 1'b0;
            state_q <= COMPARA;
          end
        end
        COMPARA: begin
          if (chunk_a != chunk_b) begin
            maior_q <= chunk_gt;
            menor_q <= ~chunk_gt;
            igual_q <= 1'b0;
            res_q   <= rel_sel(modo_q, 1'b0, chunk_gt, ~chunk_gt);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIM;
          end else if (idx_q == IDX_LAST) begin
            igual_q <= 1'b1;
            maior_q <= 1'b0;
            menor_q <= 1'b0;
            res_q   <= rel_sel(modo_q, 1'b1, 1'b0, 1'b0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIM;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        FIM: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign IGUAL     = igual_q;
  assign MAIOR     = maior_q;
  assign MENOR     = menor_q;
  assign RESULTADO = res_q;

endmodule

// File: tb/tb_comparador_seq.sv
// Bench for comparador_seq: directed table on a 16/4 instance, handshake corner
// cases, and a random sweep on 8/2 and 8/8 instances against a relational model.
module tb_comparador_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  logic        s16, g16;
  logic [15:0] a16, b16;
  logic [2:0]  m16;
  logic        bz16, dn16, ig16, ma16, me16, rs16;

  logic        s8, g8;
  logic [7:0]  a8, b8;
  logic [2:0]  m8;
  logic        bzA, dnA, igA, maA, meA, rsA;
  logic        bzB, dnB, igB, maB, meB, rsB;

  comparador_seq #(.WIDTH(16), .CHUNK(4)) d16 (
    .CLK(CLK), .RST(RST), .START(s16), .A(a16), .B(b16), .MODO(m16), .SINAL(g16),
    .BUSY(bz16), .DONE(dn16), .IGUAL(ig16), .MAIOR(ma16), .MENOR(me16), .RESULTADO(rs16));

  comparador_seq #(.WIDTH(8), .CHUNK(2)) d8a (
    .CLK(CLK), .RST(RST), .START(s8), .A(a8), .B(b8), .MODO(m8), .SINAL(g8),
    .BUSY(bzA), .DONE(dnA), .IGUAL(igA), .MAIOR(maA), .MENOR(meA), .RESULTADO(rsA));

  comparador_seq #(.WIDTH(8), .CHUNK(8)) d8b (
    .CLK(CLK), .RST(RST), .START(s8), .A(a8), .B(b8), .MODO(m8), .SINAL(g8),
    .BUSY(bzB), .DONE(dnB), .IGUAL(igB), .MAIOR(maB), .MENOR(meB), .RESULTADO(rsB));

  typedef struct {
    int   id;
    logic ig, ma, me, rs;
    int   done_cyc;
    int   j;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic [2:0]  m;
    logic        s;
    logic        ig, ma, me, rs;
    int          j;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busyc[3];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic mon(input int k, input logic bz, input logic dn, input logic ig,
                     input logic ma, input logic me, input logic rs);
    exp_t e;
    bit found;
    if (bz) busyc[k]++;
    if (dn) begin
      found = 0;
      for (int i = 0; i < sb.size(); i++) begin
        if (!found && sb[i].id == k) begin
          e = sb[i];
          sb.delete(i);
          found = 1;
        end
      end
      if (!found) chk($sformatf("d%0d_unexpected_done", k), 1, 0);
      else begin
        chk($sformatf("d%0d_igual", k), ig, e.ig);
        chk($sformatf("d%0d_maior", k), ma, e.ma);
        chk($sformatf("d%0d_menor", k), me, e.me);
        chk($sformatf("d%0d_resultado", k), rs, e.rs);
        chk($sformatf("d%0d_latency", k), cyc, e.done_cyc);
        chk($sformatf("d%0d_busy_cycles", k), busyc[k], e.j);
      end
      chk($sformatf("d%0d_onehot", k), int'(ig) + int'(ma) + int'(me), 1);
      busyc[k] = 0;
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 3; k++) busyc[k] = 0;
    end else begin
      mon(0, bz16, dn16, ig16, ma16, me16, rs16);
      mon(1, bzA, dnA, igA, maA, meA, rsA);
      mon(2, bzB, dnB, igB, maB, meB, rsB);
    end
  end

  function automatic int jcalc(input int w, input int ch, input logic [15:0] x);
    int xv = int'(x);
    for (int i = 0; i < w / ch; i++)
      if (((xv >> (w - (i + 1) * ch)) & ((1 << ch) - 1)) != 0) return i + 1;
    return w / ch;
  endfunction

  function automatic exp_t model(input int id, input int w, input int ch,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] m, input logic sg, input int t);
    exp_t e;
    int av = int'(a);
    int bv = int'(b);
    if (sg && a[w-1]) av = av - (1 << w);
    if (sg && b[w-1]) bv = bv - (1 << w);
    e.id = id;
    e.ig = (av == bv);
    e.ma = (av > bv);
    e.me = (av < bv);
    case (m)
      3'd0: e.rs = e.ig;
      3'd1: e.rs = !e.ig;
      3'd2: e.rs = e.me;
      3'd3: e.rs = e.me | e.ig;
      3'd4: e.rs = e.ma;
      3'd5: e.rs = e.ma | e.ig;
      default: e.rs = 1'b0;
    endcase
    e.j = jcalc(w, ch, a ^ b);
    e.done_cyc = t + e.j + 1;
    return e;
  endfunction

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                         input logic s, output int t);
    @(posedge CLK); #1;
    a16 = a; b16 = b; m16 = m; g16 = s; s16 = 1'b1;
    t = cyc;
    @(posedge CLK); #1;
    s16 = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit empty = 0;
    for (int i = 0; i < budget && !empty; i++) begin
      @(posedge CLK); #2;
      if (sb.size() == 0) empty = 1;
    end
    chk(nm, sb.size(), 0);
  endtask

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    exp_t e;

    tbl[0] = '{a:16'hBEEF, b:16'hBEEF, m:3'd0, s:1'b0, ig:1, ma:0, me:0, rs:1, j:4};
    tbl[1] = '{a:16'h8000, b:16'h7FFF, m:3'd4, s:1'b0, ig:0, ma:1, me:0, rs:1, j:1};
    tbl[2] = '{a:16'h8000, b:16'h7FFF, m:3'd4, s:1'b1, ig:0, ma:0, me:1, rs:0, j:1};
    tbl[3] = '{a:16'h1234, b:16'h1239, m:3'd2, s:1'b0, ig:0, ma:0, me:1, rs:1, j:4};
    tbl[4] = '{a:16'h1234, b:16'h1239, m:3'd6, s:1'b0, ig:0, ma:0, me:1, rs:0, j:4};
    tbl[5] = '{a:16'h1234, b:16'h1239, m:3'd1, s:1'b0, ig:0, ma:0, me:1, rs:1, j:4};
    tbl[6] = '{a:16'h0050, b:16'h0030, m:3'd5, s:1'b0, ig:0, ma:1, me:0, rs:1, j:3};
    tbl[7] = '{a:16'hFFFF, b:16'h0001, m:3'd3, s:1'b1, ig:0, ma:0, me:1, rs:1, j:1};
    tbl[8] = '{a:16'h0000, b:16'h0000, m:3'd7, s:1'b0, ig:1, ma:0, me:0, rs:0, j:4};
    tbl[9] = '{a:16'h0F00, b:16'h0E00, m:3'd0, s:1'b1, ig:0, ma:1, me:0, rs:0, j:2};

    RST = 1'b1;
    s16 = 0; a16 = '0; b16 = '0; m16 = '0; g16 = 0;
    s8 = 0;  a8 = '0;  b8 = '0;  m8 = '0;  g8 = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    chk("rst_busy", bz16, 0);
    chk("rst_done", dn16, 0);
    chk("rst_igual", ig16, 0);
    chk("rst_maior", ma16, 0);
    chk("rst_menor", me16, 0);
    chk("rst_resultado", rs16, 0);
    chk("rst_busy8", int'(bzA) + int'(bzB) + int'(dnA) + int'(dnB), 0);

    // Directed table on the 16-bit / 4-bit-chunk instance.
    for (int i = 0; i < 10; i++) begin
      drive16(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].s, t);
      e = '{id:0, ig:tbl[i].ig, ma:tbl[i].ma, me:tbl[i].me, rs:tbl[i].rs,
            done_cyc:t + tbl[i].j + 1, j:tbl[i].j};
      sb.push_back(e);
      wait_idle(30, $sformatf("tbl%0d_drain", i));
      repeat (2) @(posedge CLK);
      #1;
      chk($sformatf("tbl%0d_hold_igual", i), ig16, tbl[i].ig);
      chk($sformatf("tbl%0d_hold_maior", i), ma16, tbl[i].ma);
      chk($sformatf("tbl%0d_hold_menor", i), me16, tbl[i].me);
      chk($sformatf("tbl%0d_hold_res", i), rs16, tbl[i].rs);
      chk($sformatf("tbl%0d_idle", i), int'(bz16) + int'(dn16), 0);
    end

    // Second START while busy is dropped; inputs changed after capture are ignored.
    @(posedge CLK); #1;
    a16 = 16'h00F0; b16 = 16'h00F1; m16 = 3'd2; g16 = 0; s16 = 1'b1;
    t = cyc;
    @(posedge CLK); #1;
    s16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0000; m16 = 3'd4;
    chk("cap_busy", bz16, 1);
    chk("cap_clear_flags", int'(ig16) + int'(ma16) + int'(me16) + int'(rs16), 0);
    e = '{id:0, ig:0, ma:0, me:1, rs:1, done_cyc:t + 5, j:4};
    sb.push_back(e);
    @(posedge CLK); #1;
    s16 = 1'b1;
    @(posedge CLK); #1;
    s16 = 1'b0;
    wait_idle(30, "ignored_start_drain");
    repeat (8) @(posedge CLK);
    #1;
    chk("ignored_start_no_busy", bz16, 0);
    chk("ignored_start_flags", ig16 ? 2 : (me16 ? 1 : 0), 1);

    // Reset in the cycle after capture aborts the scan.
    @(posedge CLK); #1;
    a16 = 16'h0001; b16 = 16'h0002; m16 = 3'd0; g16 = 0; s16 = 1'b1;
    @(posedge CLK); #1;
    s16 = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_busy", bz16, 0);
    chk("abort_done", dn16, 0);
    chk("abort_flags", int'(ig16) + int'(ma16) + int'(me16) + int'(rs16), 0);
    repeat (8) @(posedge CLK);
    #1;
    chk("abort_no_done", dn16, 0);
    drive16(16'h0000, 16'h0000, 3'd3, 1'b0, t);
    e = '{id:0, ig:1, ma:0, me:0, rs:1, done_cyc:t + 5, j:4};
    sb.push_back(e);
    wait_idle(30, "after_abort_drain");

    // Random sweep on the 8-bit instances, chunk 2 and chunk 8.
    for (int n = 0; n < 1000; n++) begin
      @(posedge CLK); #1;
      a8 = 8'($urandom);
      b8 = (n % 4 == 0) ? a8 : 8'($urandom);
      if (n % 7 == 1) b8 = a8 ^ 8'h01;
      m8 = 3'($urandom_range(0, 7));
      g8 = 1'($urandom);
      s8 = 1'b1;
      t = cyc;
      sb.push_back(model(1, 8, 2, {8'h00, a8}, {8'h00, b8}, m8, g8, t));
      sb.push_back(model(2, 8, 8, {8'h00, a8}, {8'h00, b8}, m8, g8, t));
      @(posedge CLK); #1;
      s8 = 1'b0;
      wait_idle(30, $sformatf("sweep%0d_drain", n));
    end

    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
